corr_integration_ctrl: RTL and testbench

//  Run-control and readout scheduler for the single-bin FX correlator.

---
 rtl/corr_integration_ctrl_if.sv | 41 ++++
 rtl/corr_integration_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_corr_integration_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/corr_integration_ctrl_if.sv
// ============================================================================
// Module : corr_integration_ctrl_if
// Brief  : Dump handshake bundle between the correlator run controller and
//          its downstream consumer (held dump words, valid/ready).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface corr_integration_ctrl_if #(
  parameter int DOUT_WIDTH = 32
) ();

  logic [DOUT_WIDTH-1:0] dump_aa;
  logic [DOUT_WIDTH-1:0] dump_bb;
  logic [DOUT_WIDTH-1:0] dump_ab_re;
  logic [DOUT_WIDTH-1:0] dump_ab_im;
  logic                  dump_valid;
  logic                  dump_ready;
`ifdef CORR_CTRL_TIMESTAMP_EN
  logic [63:0]           dump_tstamp;
`endif

  modport master (
    output dump_aa, dump_bb, dump_ab_re, dump_ab_im, dump_valid,
`ifdef CORR_CTRL_TIMESTAMP_EN
    output dump_tstamp,
`endif
    input  dump_ready
  );

  modport slave (
    input  dump_aa, dump_bb, dump_ab_re, dump_ab_im, dump_valid,
`ifdef CORR_CTRL_TIMESTAMP_EN
    input  dump_tstamp,
`endif
    output dump_ready
  );

endinterface

`default_nettype wire

// File: rtl/corr_integration_ctrl.sv
// ============================================================================
// Module : corr_integration_ctrl
// Brief  : Run control and dump readout scheduler for the single-bin FX
//          correlator. Optional feature macro: CORR_CTRL_TIMESTAMP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module corr_integration_ctrl #(
  parameter int DOUT_WIDTH   = 32,
  parameter int DFT_LEN      = 128,
  parameter int FLUSH_CYCLES = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  cfg_start,
  input  wire logic                  cfg_stop,
  input  wire logic [31:0]           cfg_acc_len,
  input  wire logic [31:0]           cfg_delay_line,
  input  wire logic                  din_valid_in,
  output logic                       corr_din_valid,
  output logic                       corr_rst,
  output logic [31:0]                corr_acc_len,
  output logic [31:0]                corr_delay_line,
  input  wire logic [DOUT_WIDTH-1:0] corr_aa,
  input  wire logic [DOUT_WIDTH-1:0] corr_bb,
  input  wire logic [DOUT_WIDTH-1:0] corr_ab_re,
  input  wire logic [DOUT_WIDTH-1:0] corr_ab_im,
  input  wire logic                  corr_dout_valid,
  corr_integration_ctrl_if.master    dmp,
  output logic                       busy,
  output logic                       overrun,
  output logic [CNT_WIDTH-1:0]       dump_count,
  output logic [CNT_WIDTH-1:0]       drop_count
);

  localparam int          FW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [31:0] C_DL_MAX   = 32'(DFT_LEN - 1);
  localparam logic [FW-1:0] C_FLUSH  = FW'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_DISCARD = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [31:0]           acc_len_q, acc_len_d;
  logic [31:0]           delay_line_q, delay_line_d;
  logic                  overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]  dump_count_q, dump_count_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [DOUT_WIDTH-1:0] aa_q, aa_d, bb_q, bb_d, re_q, re_d, im_q, im_d;
  logic                  valid_q, valid_d;
  logic                  w_xfer;
  logic                  w_capture;

  assign w_xfer = valid_q & dmp.dump_ready;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    acc_len_d    = acc_len_q;
    delay_line_d = delay_line_q;
    overrun_d    = overrun_q;
    dump_count_d = dump_count_q;
    drop_count_d = drop_count_q;
    aa_d         = aa_q;
    bb_d         = bb_q;
    re_d         = re_q;
    im_d         = im_q;
    valid_d      = valid_q;
    w_capture    = 1'b0;

    if (w_xfer) begin
      valid_d      = 1'b0;
      dump_count_d = dump_count_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // stop has priority over a simultaneous start
        if (cfg_start && !cfg_stop) begin
          state_d      = S_FLUSH;
          flush_cnt_d  = C_FLUSH;
          acc_len_d    = cfg_acc_len;
          delay_line_d = (cfg_delay_line > C_DL_MAX) ? C_DL_MAX : cfg_delay_line;
          overrun_d    = 1'b0;
          dump_count_d = '0;
          drop_count_d = '0;
        end
      end
      S_FLUSH: begin
        if (cfg_stop) begin
          state_d = S_IDLE;
        end else if (flush_cnt_q <= FW'(1)) begin
          state_d = S_DISCARD;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      S_DISCARD: begin
        if (cfg_stop) begin
          state_d = S_DRAIN;
        end else if (corr_dout_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (corr_dout_valid) begin
          if (!valid_q || w_xfer) begin
            w_capture = 1'b1;
            aa_d      = corr_aa;
            bb_d      = corr_bb;
            re_d      = corr_ab_re;
            im_d      = corr_ab_im;
            valid_d   = 1'b1;
          end else begin
            overrun_d = 1'b1;
            if (drop_count_q != {CNT_WIDTH{1'b1}}) begin
              drop_count_d = drop_count_q + 1'b1;
            end
          end
        end
        if (cfg_stop) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      flush_cnt_q  <= '0;
      acc_len_q    <= '0;
      delay_line_q <= '0;
      overrun_q    <= 1'b0;
      dump_count_q <= '0;
      drop_count_q <= '0;
      aa_q         <= '0;
      bb_q         <= '0;
      re_q         <= '0;
      im_q         <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      acc_len_q    <= acc_len_d;
      delay_line_q <= delay_line_d;
      overrun_q    <= overrun_d;
      dump_count_q <= dump_count_d;
      drop_count_q <= drop_count_d;
      aa_q         <= aa_d;
      bb_q         <= bb_d;
      re_q         <= re_d;
      im_q         <= im_d;
      valid_q      <= valid_d;
    end
  end

`ifdef CORR_CTRL_TIMESTAMP_EN
  logic [63:0] ts_q, ts_d;
  logic [63:0] tstamp_q, tstamp_d;

  always_comb begin
    ts_d     = ts_q + 64'd1;
    tstamp_d = w_capture ? ts_q : tstamp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      tstamp_q <= '0;
    end else begin
      ts_q     <= ts_d;
      tstamp_q <= tstamp_d;
    end
  end

  assign dmp.dump_tstamp = tstamp_q;
`endif

  // gate is a pure decode of registered state so it follows din_valid_in with no delay
  assign corr_din_valid  = din_valid_in & ((state_q == S_DISCARD) | (state_q == S_RUN));
  assign corr_rst        = (state_q == S_IDLE) | (state_q == S_FLUSH);
  assign corr_acc_len    = acc_len_q;
  assign corr_delay_line = delay_line_q;
  assign busy            = (state_q != S_IDLE);
  assign overrun         = overrun_q;
  assign dump_count      = dump_count_q;
  assign drop_count      = drop_count_q;

  assign dmp.dump_aa    = aa_q;
  assign dmp.dump_bb    = bb_q;
  assign dmp.dump_ab_re = re_q;
  assign dmp.dump_ab_im = im_q;
  assign dmp.dump_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_corr_integration_ctrl.sv
// ============================================================================
// Module : tb_corr_integration_ctrl
// Brief  : Scoreboard bench for corr_integration_ctrl run control and readout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_corr_integration_ctrl;

  localparam int DW = 32;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] aa;
    logic [DW-1:0] bb;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } dump_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [31:0]   cfg_acc_len = '0;
  logic [31:0]   cfg_delay_line = '0;
  logic          din_valid_in = 1'b0;
  logic          corr_din_valid;
  logic          corr_rst;
  logic [31:0]   corr_acc_len;
  logic [31:0]   corr_delay_line;
  logic [DW-1:0] corr_aa = '0, corr_bb = '0, corr_ab_re = '0, corr_ab_im = '0;
  logic          corr_dout_valid = 1'b0;
  logic          busy, overrun;
  logic [CW-1:0] dump_count, drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  dump_t sb_q[$];
`ifdef CORR_CTRL_TIMESTAMP_EN
  logic [63:0] last_ts = '0;
  bit          have_ts = 1'b0;
`endif

  corr_integration_ctrl_if #(.DOUT_WIDTH(DW)) dmp_if ();

  corr_integration_ctrl #(
    .DOUT_WIDTH(DW), .DFT_LEN(128), .FLUSH_CYCLES(16), .CNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_acc_len(cfg_acc_len), .cfg_delay_line(cfg_delay_line),
    .din_valid_in(din_valid_in), .corr_din_valid(corr_din_valid),
    .corr_rst(corr_rst), .corr_acc_len(corr_acc_len), .corr_delay_line(corr_delay_line),
    .corr_aa(corr_aa), .corr_bb(corr_bb), .corr_ab_re(corr_ab_re), .corr_ab_im(corr_ab_im),
    .corr_dout_valid(corr_dout_valid),
    .dmp(dmp_if.master),
    .busy(busy), .overrun(overrun), .dump_count(dump_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input dump_t d, input bit expect_it);
    corr_aa = d.aa; corr_bb = d.bb; corr_ab_re = d.re; corr_ab_im = d.im;
    corr_dout_valid = 1'b1;
    if (expect_it) sb_q.push_back(d);
    tick();
    corr_dout_valid = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] dl, input logic [31:0] al);
    cfg_delay_line = dl;
    cfg_acc_len = al;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // transfer happens on the next posedge; inputs are stable at the negedge
  always @(negedge clk) begin
    if (dmp_if.dump_valid && dmp_if.dump_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_dump", 64'(sb_q.size()), 64'd1);
      end else begin
        dump_t e;
        e = sb_q.pop_front();
        check("sb_aa", 64'(dmp_if.dump_aa), 64'(e.aa));
        check("sb_bb", 64'(dmp_if.dump_bb), 64'(e.bb));
        check("sb_ab_re", 64'(dmp_if.dump_ab_re), 64'(e.re));
        check("sb_ab_im", 64'(dmp_if.dump_ab_im), 64'(e.im));
`ifdef CORR_CTRL_TIMESTAMP_EN
        if (have_ts) check("tstamp_increasing", 64'(dmp_if.dump_tstamp > last_ts), 64'd1);
        last_ts = dmp_if.dump_tstamp;
        have_ts = 1'b1;
`endif
      end
    end
  end

  initial begin
    int n;
    dump_t d;
    dmp_if.dump_ready = 1'b0;
    din_valid_in = 1'b1;

    // reset
    #12;
    check("rst_corr_rst", 64'(corr_rst), 64'd1);
    check("rst_dump_valid", 64'(dmp_if.dump_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dump_count", 64'(dump_count), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_gate", 64'(corr_din_valid), 64'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_after_rst", 64'(busy), 64'd0);

    // start with clamped delay line, then measure flush length
    start_run(32'd300, 32'd1000);
    check("clamp_delay_line", 64'(corr_delay_line), 64'd127);
    check("acc_len_latched", 64'(corr_acc_len), 64'd1000);
    check("flush_gate_closed", 64'(corr_din_valid), 64'd0);
    cfg_delay_line = 32'd5;
    cfg_acc_len = 32'd7;
    n = 0;
    while (corr_rst && n < 100) begin
      tick();
      n++;
    end
    check("flush_cycles", 64'(n), 64'd16);
    check("gate_open", 64'(corr_din_valid), 64'd1);
    check("cfg_frozen", 64'(corr_delay_line), 64'd127);

    // first dump discarded, second captured with 1-cycle latency
    d = '{aa: 32'd5, bb: 32'd1, re: 32'd2, im: 32'd3};
    send(d, 1'b0);
    check("discard_no_valid", 64'(dmp_if.dump_valid), 64'd0);
    d = '{aa: 32'd7, bb: 32'd11, re: -32'sd3, im: -32'sd9};
    send(d, 1'b1);
    check("capture_valid", 64'(dmp_if.dump_valid), 64'd1);
    check("capture_aa", 64'(dmp_if.dump_aa), 64'd7);
    check("capture_ab_re", 64'(dmp_if.dump_ab_re), 64'(32'hFFFF_FFFD));

    // backpressure: three more dumps are dropped
    for (int i = 0; i < 3; i++) begin
      d = '{aa: 32'(8 + i), bb: 32'd0, re: 32'd0, im: 32'd0};
      send(d, 1'b0);
    end
    check("overrun_set", 64'(overrun), 64'd1);
    check("drop_count_3", 64'(drop_count), 64'd3);
    check("held_aa", 64'(dmp_if.dump_aa), 64'd7);
    dmp_if.dump_ready = 1'b1;
    tick();
    check("dump_count_1", 64'(dump_count), 64'd1);
    check("emptied", 64'(dmp_if.dump_valid), 64'd0);

    // back-to-back dumps with ready high: capture while emptying
    for (int i = 0; i < 4; i++) begin
      d = '{aa: 32'(100 + i), bb: $urandom, re: $urandom, im: $urandom};
      send(d, 1'b1);
    end
    tick();
    check("dump_count_5", 64'(dump_count), 64'd5);
    check("no_new_drops", 64'(drop_count), 64'd3);

    // stop with a pending dump: stays busy until it is taken
    dmp_if.dump_ready = 1'b0;
    d = '{aa: 32'd50, bb: 32'd51, re: -32'sd52, im: 32'd53};
    send(d, 1'b1);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("drain_gate_closed", 64'(corr_din_valid), 64'd0);
    check("drain_corr_rst", 64'(corr_rst), 64'd0);
    d = '{aa: 32'd99, bb: 32'd0, re: 32'd0, im: 32'd0};
    send(d, 1'b0);
    repeat (4) tick();
    check("drain_busy", 64'(busy), 64'd1);
    check("drain_ignores_late", 64'(drop_count), 64'd3);
    check("drain_held_aa", 64'(dmp_if.dump_aa), 64'd50);
    dmp_if.dump_ready = 1'b1;
    tick();
    dmp_if.dump_ready = 1'b0;
    tick();
    check("drain_to_idle", 64'(busy), 64'd0);
    check("idle_corr_rst", 64'(corr_rst), 64'd1);
    check("dump_count_6", 64'(dump_count), 64'd6);

    // start and stop together: stop wins
    cfg_start = 1'b1;
    cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    tick();
    check("start_stop_idle", 64'(busy), 64'd0);

    // new run clears counts, then async reset mid-run
    start_run(32'd50, 32'd20);
    check("dl_unclamped", 64'(corr_delay_line), 64'd50);
    check("counts_cleared", 64'(dump_count), 64'd0);
    check("overrun_cleared", 64'(overrun), 64'd0);
    n = 0;
    while (corr_rst && n < 100) begin
      tick();
      n++;
    end
    check("flush_cycles_2", 64'(n), 64'd16);
    d = '{aa: 32'd1, bb: 32'd1, re: 32'd1, im: 32'd1};
    send(d, 1'b0);
    d = '{aa: 32'd77, bb: 32'd78, re: 32'd79, im: 32'd80};
    send(d, 1'b1);
    check("pre_reset_valid", 64'(dmp_if.dump_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_valid", 64'(dmp_if.dump_valid), 64'd0);
    check("async_rst_corr_rst", 64'(corr_rst), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
